// File: rtl/hcordic_pkg.sv
// rtl/hcordic_pkg.sv - shared CORDIC constants, zout field layout and normalise FSM states
package hcordic_pkg;

    localparam logic [1:0] mode_circular   = 2'b01;
    localparam logic [1:0] mode_linear     = 2'b00;
    localparam logic [1:0] mode_hyperbolic = 2'b11;

    localparam logic [1:0] no_idle     = 2'b00;
    localparam logic [1:0] allign_idle = 2'b01;
    localparam logic [1:0] put_idle    = 2'b10;

    localparam int ZOUT_SIGN     = 35;
    localparam int ZOUT_EXP_MSB  = 34;
    localparam int ZOUT_EXP_LSB  = 27;
    localparam int ZOUT_MANT_MSB = 26;

    // -126 as an 8-bit two's-complement exponent; shifting halts here (denormal)
    localparam logic [7:0]  EXP_FLOOR  = 8'h82;
    localparam logic [26:0] MANT_CARRY = 27'h4000000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_ROUND = 2'b10,
        ST_DONE  = 2'b11
    } norm_state_t;

endpackage

// File: rtl/round_mant27.sv
// rtl/round_mant27.sv - 27-bit mantissa rounder; NORM_RNE_ROUND_EN selects round-to-nearest-even,
// otherwise the mantissa is truncated and carry is never raised.
module round_mant27
    import hcordic_pkg::*;
(
    input  logic [26:0] mant_in,
    input  logic        guard,
    input  logic        sticky,
    output logic [26:0] mant_out,
    output logic        carry
);

`ifdef NORM_RNE_ROUND_EN
    logic        round_up;
    logic [27:0] sum;

    assign round_up = guard & (sticky | mant_in[0]);
    assign sum      = {1'b0, mant_in} + {27'd0, round_up};
    assign carry    = sum[27];
    // An all-ones mantissa rolls over to 1.000... and the caller bumps the exponent
    assign mant_out = carry ? MANT_CARRY : sum[26:0];
`else
    logic unused_round_bits;

    assign unused_round_bits = guard ^ sticky;
    assign mant_out          = mant_in;
    assign carry             = 1'b0;
`endif

endmodule

// File: rtl/normalise_prod_y.sv
// rtl/normalise_prod_y.sv - iterative normalise/round of the Y-path product with valid/ready handshake;
// rounding mode chosen by NORM_RNE_ROUND_EN (defined: RNE, undefined: truncate).
module normalise_prod_y
    import hcordic_pkg::*;
(
    input  logic        clock,
    input  logic        reset_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [1:0]  idle_Multiply,
    input  logic [35:0] zout_Multiply,
    input  logic [49:0] productout_Multiply,
    input  logic [35:0] cout_Multiply,
    input  logic [31:0] sout_Multiply,
    input  logic [1:0]  modeout_Multiply,
    input  logic        operationout_Multiply,
    input  logic        NatLogFlagout_Multiply,
    input  logic [7:0]  InsTag_Multiply,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [35:0] zout_Normalise,
    output logic [35:0] cout_Normalise,
    output logic [31:0] sout_Normalise,
    output logic [1:0]  modeout_Normalise,
    output logic        operationout_Normalise,
    output logic        NatLogFlagout_Normalise,
    output logic [7:0]  InsTag_Normalise,
    output logic [1:0]  idle_Normalise
);

    norm_state_t state_q, state_d;

    logic [49:0] prod_q;
    logic [7:0]  exp_q;
    logic        sign_q;

    logic [7:0]  exp_dec;
    logic        shift_stop;
    logic        shift_last;
    logic        prod_zero;
    logic [26:0] mant_rnd;
    logic        mant_carry;
    logic [7:0]  exp_rnd;
    logic [26:0] mant_final;

    assign exp_dec    = exp_q - 8'd1;
    assign shift_stop = prod_q[49] | (exp_q == EXP_FLOOR);
    // Look one shift ahead so the final shift and the move to ROUND share an edge
    assign shift_last = prod_q[48] | (exp_dec == EXP_FLOOR);
    assign prod_zero  = (prod_q == 50'd0);

    round_mant27 u_round (
        .mant_in  (prod_q[49:23]),
        .guard    (prod_q[22]),
        .sticky   (|prod_q[21:0]),
        .mant_out (mant_rnd),
        .carry    (mant_carry)
    );

    assign exp_rnd    = prod_zero ? 8'd0 : exp_q + {7'd0, mant_carry};
    assign mant_final = prod_zero ? 27'd0 : mant_rnd;

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    if (idle_Multiply != no_idle) begin
                        state_d = ST_DONE;
                    end else if ((productout_Multiply == 50'd0) || productout_Multiply[49]) begin
                        state_d = ST_ROUND;
                    end else begin
                        state_d = ST_SHIFT;
                    end
                end
            end
            ST_SHIFT: begin
                if (shift_stop || shift_last) begin
                    state_d = ST_ROUND;
                end
            end
            ST_ROUND: state_d = ST_DONE;
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            prod_q                  <= '0;
            exp_q                   <= '0;
            sign_q                  <= 1'b0;
            zout_Normalise          <= '0;
            cout_Normalise          <= '0;
            sout_Normalise          <= '0;
            modeout_Normalise       <= '0;
            operationout_Normalise  <= 1'b0;
            NatLogFlagout_Normalise <= 1'b0;
            InsTag_Normalise        <= '0;
            idle_Normalise          <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        prod_q                  <= productout_Multiply;
                        exp_q                   <= zout_Multiply[ZOUT_EXP_MSB:ZOUT_EXP_LSB];
                        sign_q                  <= zout_Multiply[ZOUT_SIGN];
                        cout_Normalise          <= cout_Multiply;
                        sout_Normalise          <= sout_Multiply;
                        modeout_Normalise       <= modeout_Multiply;
                        operationout_Normalise  <= operationout_Multiply;
                        NatLogFlagout_Normalise <= NatLogFlagout_Multiply;
                        InsTag_Normalise        <= InsTag_Multiply;
                        idle_Normalise          <= idle_Multiply;
                        if (idle_Multiply != no_idle) begin
                            zout_Normalise <= zout_Multiply;
                        end
                    end
                end
                ST_SHIFT: begin
                    if (!shift_stop) begin
                        prod_q <= prod_q << 1;
                        exp_q  <= exp_dec;
                    end
                end
                ST_ROUND: begin
                    zout_Normalise <= {sign_q, exp_rnd, mant_final};
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_normalise_prod_y.sv
// tb/tb_normalise_prod_y.sv - self-checking bench: vector table, random words vs reference model, backpressure and reset
module tb_normalise_prod_y;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  idle_Multiply;
    logic [35:0] zout_Multiply;
    logic [49:0] productout_Multiply;
    logic [35:0] cout_Multiply;
    logic [31:0] sout_Multiply;
    logic [1:0]  modeout_Multiply;
    logic        operationout_Multiply;
    logic        NatLogFlagout_Multiply;
    logic [7:0]  InsTag_Multiply;
    logic        out_valid;
    logic        out_ready;
    logic [35:0] zout_Normalise;
    logic [35:0] cout_Normalise;
    logic [31:0] sout_Normalise;
    logic [1:0]  modeout_Normalise;
    logic        operationout_Normalise;
    logic        NatLogFlagout_Normalise;
    logic [7:0]  InsTag_Normalise;
    logic [1:0]  idle_Normalise;

    always #5 clock = ~clock;

    normalise_prod_y dut (
        .clock                   (clock),
        .reset_n                 (reset_n),
        .in_valid                (in_valid),
        .in_ready                (in_ready),
        .idle_Multiply           (idle_Multiply),
        .zout_Multiply           (zout_Multiply),
        .productout_Multiply     (productout_Multiply),
        .cout_Multiply           (cout_Multiply),
        .sout_Multiply           (sout_Multiply),
        .modeout_Multiply        (modeout_Multiply),
        .operationout_Multiply   (operationout_Multiply),
        .NatLogFlagout_Multiply  (NatLogFlagout_Multiply),
        .InsTag_Multiply         (InsTag_Multiply),
        .out_valid               (out_valid),
        .out_ready               (out_ready),
        .zout_Normalise          (zout_Normalise),
        .cout_Normalise          (cout_Normalise),
        .sout_Normalise          (sout_Normalise),
        .modeout_Normalise       (modeout_Normalise),
        .operationout_Normalise  (operationout_Normalise),
        .NatLogFlagout_Normalise (NatLogFlagout_Normalise),
        .InsTag_Normalise        (InsTag_Normalise),
        .idle_Normalise          (idle_Normalise)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       name;
        logic [1:0]  idle;
        logic [35:0] zin;
        logic [49:0] prod;
        logic [35:0] zexp;
        int          lat;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Reference: normalise by counting shifts arithmetically, then round the 27-bit field
    function automatic void model(input logic [1:0] idle, input logic [35:0] zin,
                                  input logic [49:0] prod, output logic [35:0] zexp, output int lat);
        logic [49:0] p;
        logic [7:0]  e;
        logic [26:0] m;
        int          k;
        if (idle != 2'b00) begin
            zexp = zin;
            lat  = 1;
            return;
        end
        if (prod == 50'd0) begin
            zexp = {zin[35], 35'd0};
            lat  = 2;
            return;
        end
        p = prod;
        e = zin[34:27];
        k = 0;
        while (p[49] == 1'b0 && e != 8'h82) begin
            p = p << 1;
            e = e - 8'd1;
            k++;
        end
        if (prod[49]) lat = 2;
        else if (k == 0) lat = 3;
        else lat = k + 2;
        m = p[49:23];
`ifdef NORM_RNE_ROUND_EN
        if (p[22] && ((p[21:0] != 22'd0) || m[0])) begin
            if (m == 27'h7FFFFFF) begin
                m = 27'h4000000;
                e = e + 8'd1;
            end else begin
                m = m + 27'd1;
            end
        end
`endif
        zexp = {zin[35], e, m};
    endfunction

    task automatic drive_word(input logic [1:0] idle, input logic [35:0] zin, input logic [49:0] prod,
                              input logic [7:0] tag);
        logic [63:0] r;
        r = {$urandom, $urandom};
        idle_Multiply          = idle;
        zout_Multiply          = zin;
        productout_Multiply    = prod;
        cout_Multiply          = r[35:0];
        sout_Multiply          = $urandom;
        modeout_Multiply       = 2'($urandom_range(0, 3));
        operationout_Multiply  = 1'($urandom_range(0, 1));
        NatLogFlagout_Multiply = 1'($urandom_range(0, 1));
        InsTag_Multiply        = tag;
        in_valid               = 1'b1;
    endtask

    task automatic run_word(input string name, input logic [1:0] idle, input logic [35:0] zin,
                            input logic [49:0] prod, input logic [35:0] zexp, input int lat);
        int          edges;
        logic [35:0] c_exp;
        logic [31:0] s_exp;
        logic [1:0]  m_exp;
        logic        o_exp;
        logic        n_exp;
        logic [7:0]  tag;
        tag   = 8'($urandom);
        edges = 0;
        while (!in_ready && edges < 100) begin
            @(posedge clock); #1;
            edges++;
        end
        chk({name, " in_ready"}, 64'(in_ready), 64'd1);
        drive_word(idle, zin, prod, tag);
        c_exp = cout_Multiply;
        s_exp = sout_Multiply;
        m_exp = modeout_Multiply;
        o_exp = operationout_Multiply;
        n_exp = NatLogFlagout_Multiply;
        @(posedge clock); #1;
        in_valid            = 1'b0;
        productout_Multiply = ~prod;
        zout_Multiply       = ~zin;
        InsTag_Multiply     = ~tag;
        edges = 1;
        while (!out_valid && edges < 100) begin
            @(posedge clock); #1;
            edges++;
        end
        chk({name, " latency"}, 64'(edges), 64'(lat));
        chk({name, " zout"}, 64'(zout_Normalise), 64'(zexp));
        chk({name, " tag"}, 64'(InsTag_Normalise), 64'(tag));
        chk({name, " side"}, {cout_Normalise, modeout_Normalise, operationout_Normalise,
                              NatLogFlagout_Normalise, idle_Normalise},
            {c_exp, m_exp, o_exp, n_exp, idle});
        chk({name, " sout"}, 64'(sout_Normalise), 64'(s_exp));
        out_ready = 1'b1;
        @(posedge clock); #1;
        out_ready = 1'b0;
        chk({name, " post"}, {62'd0, in_ready, out_valid}, 64'b10);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        logic [35:0] zexp;
        logic [35:0] held;
        logic [63:0] r;
        logic [1:0]  idle;
        logic [49:0] prod;
        logic [35:0] zin;
        int          lat;

        vecs[0] = '{"bypass_allign", 2'b01, 36'h123456789, 50'h1, 36'h123456789, 1};
        vecs[1] = '{"bypass_put", 2'b10, 36'hFEDCBA987, 50'h0, 36'hFEDCBA987, 1};
        vecs[2] = '{"normalised", 2'b00, {1'b0, 8'h05, 27'd0}, 50'h2_0000_0000_0000,
                    {1'b0, 8'h05, 27'h4000000}, 2};
        vecs[3] = '{"shift3", 2'b00, {1'b0, 8'h05, 27'd0}, 50'h0_4000_0000_0000,
                    {1'b0, 8'h02, 27'h4000000}, 5};
        vecs[4] = '{"zero", 2'b00, {1'b1, 8'h10, 27'd0}, 50'h0, 36'h800000000, 2};
        vecs[5] = '{"floor", 2'b00, {1'b1, 8'h84, 27'd0}, 50'h1, {1'b1, 8'h82, 27'd0}, 4};
        vecs[6] = '{"at_floor", 2'b00, {1'b0, 8'h82, 27'd0}, 50'h1_0000_0000_0000,
                    {1'b0, 8'h82, 27'h2000000}, 3};
`ifdef NORM_RNE_ROUND_EN
        vecs[7] = '{"carry", 2'b00, {1'b0, 8'h05, 27'd0}, 50'h3_FFFF_FFC0_0000,
                    {1'b0, 8'h06, 27'h4000000}, 2};
        vecs[8] = '{"carry_wrap", 2'b00, {1'b1, 8'hFF, 27'd0}, 50'h3_FFFF_FFC0_0000,
                    {1'b1, 8'h00, 27'h4000000}, 2};
`else
        vecs[7] = '{"carry", 2'b00, {1'b0, 8'h05, 27'd0}, 50'h3_FFFF_FFC0_0000,
                    {1'b0, 8'h05, 27'h7FFFFFF}, 2};
        vecs[8] = '{"carry_wrap", 2'b00, {1'b1, 8'hFF, 27'd0}, 50'h3_FFFF_FFC0_0000,
                    {1'b1, 8'hFF, 27'h7FFFFFF}, 2};
`endif

        reset_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        drive_word(2'b00, 36'd0, 50'd0, 8'd0);
        in_valid = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        chk("reset handshake", {62'd0, in_ready, out_valid}, 64'b10);
        chk("reset zout", 64'(zout_Normalise), 64'd0);
        chk("reset side", {cout_Normalise, InsTag_Normalise, idle_Normalise}, 64'd0);
        reset_n = 1'b1;
        @(posedge clock); #1;

        for (int i = 0; i < 9; i++) begin
            run_word(vecs[i].name, vecs[i].idle, vecs[i].zin, vecs[i].prod, vecs[i].zexp, vecs[i].lat);
        end

        for (int i = 0; i < 200; i++) begin
            r    = {$urandom, $urandom};
            prod = r[49:0] >> $urandom_range(0, 50);
            r    = {$urandom, $urandom};
            zin  = r[35:0];
            idle = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 2)) : 2'b00;
            model(idle, zin, prod, zexp, lat);
            run_word("random", idle, zin, prod, zexp, lat);
        end

        // Backpressure: result must hold while out_ready stays low, and new words are refused
        zin = {1'b0, 8'h40, 27'd0};
        prod = 50'h0_0123_4567_89AB;
        model(2'b00, zin, prod, zexp, lat);
        drive_word(2'b00, zin, prod, 8'h5A);
        @(posedge clock); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 100) begin
            @(posedge clock); #1;
            lat++;
        end
        chk("bp valid", 64'(out_valid), 64'd1);
        held = zout_Normalise;
        chk("bp zout", 64'(held), 64'(zexp));
        drive_word(2'b01, 36'hABCDEF012, 50'h1, 8'hA5);
        for (int i = 0; i < 10; i++) begin
            @(posedge clock); #1;
            chk("bp hold", {zout_Normalise, InsTag_Normalise, in_ready, out_valid},
                {held, 8'h5A, 1'b0, 1'b1});
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clock); #1;
        out_ready = 1'b0;
        chk("bp release", {62'd0, in_ready, out_valid}, 64'b10);

        // Reset in the middle of a long shift run discards the word
        drive_word(2'b00, {1'b1, 8'h10, 27'd0}, 50'h1, 8'h77);
        @(posedge clock); #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clock);
        #1;
        chk("mid shift busy", {62'd0, in_ready, out_valid}, 64'b00);
        reset_n = 1'b0;
        #1;
        chk("mid reset handshake", {62'd0, in_ready, out_valid}, 64'b10);
        chk("mid reset zout", 64'(zout_Normalise), 64'd0);
        chk("mid reset tag", 64'(InsTag_Normalise), 64'd0);
        @(posedge clock); #1;
        reset_n = 1'b1;
        @(posedge clock); #1;
        run_word("after reset", vecs[3].idle, vecs[3].zin, vecs[3].prod, vecs[3].zexp, vecs[3].lat);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/normalise_prod_y.md
# normalise_prod_y

Iterative normalise-and-round stage sitting directly downstream of the Y-path multiply stage. It accepts the 50-bit mantissa product and the provisional `zout` word (sign, exponent, zero mantissa) from that stage. It left-shifts the product one bit per cycle until the leading one reaches bit 49, then rounds to a 27-bit mantissa and emits a packed 36-bit `zout` to the next CORDIC stage. It uses a valid/ready handshake, so the multi-cycle normalise can stall upstream.

## Interface
- `EXP_FLOOR`, 8'h82: signed exponent (-126) below which shifting stops (denormal result).
- `clock`  in  1  sole clock, rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  upstream word valid.
- `in_ready`  out  1  stage can accept (state IDLE).
- `idle_Multiply`  in  2  `no_idle`=00, `allign_idle`=01, `put_idle`=10.
- `zout_Multiply`  in  36  [35] sign, [34:27] exponent (signed), [26:0] mantissa.
- `productout_Multiply`  in  50  unnormalised product.
- `cout_Multiply` 36, `sout_Multiply` 32, `modeout_Multiply` 2, `operationout_Multiply` 1, `NatLogFlagout_Multiply` 1, `InsTag_Multiply` 8  in  sideband fields.
- `out_valid`  out  1  result valid (state DONE).
- `out_ready`  in  1  downstream accepts.
- `zout_Normalise`  out  36  normalised, rounded z.
- `cout_Normalise`, `sout_Normalise`, `modeout_Normalise`, `operationout_Normalise`, `NatLogFlagout_Normalise`, `InsTag_Normalise`, `idle_Normalise`  out  as inputs  registered sideband.

## Operation
- FSM states: IDLE, SHIFT, ROUND, DONE.
- IDLE: `in_ready`=1. On `in_valid`:
  - Capture all inputs.
  - If idle ≠ `no_idle`: `zout_Normalise` ← `zout_Multiply` unchanged, go to DONE (bypass).
  - Else if product==0: go to ROUND.
  - Else if product[49]==1: go to ROUND.
  - Else: go to SHIFT.
- SHIFT, once per cycle:
  - If product[49]==1 or exponent==`EXP_FLOOR`: go to ROUND.
  - Otherwise: product ← product<<1, exponent ← exponent−1.
  - At most 49 SHIFT iterations.
- ROUND:
  - mant = product[49:23], guard = product[22], sticky = |product[21:0].
  - Rounding is per Configuration.
  - A carry out of mant[26] sets mant = 27'h4000000 and exponent+1. The exponent wraps modulo 256 with no saturation.
  - Zero product gives mantissa 0 and exponent 0, with the sign kept.
  - Go to DONE.
- DONE: `out_valid`=1. All outputs are held stable until `out_ready`, then go to IDLE.
- Sign bit [35] always passes through untouched.
- Sideband outputs update only on accept.

## Timing
- Reset values: state IDLE, `in_ready`=1 (follows state), `out_valid`=0, all data outputs 0.
- Reset mid-operation aborts the in-flight word, which is discarded.
- Latency from accept edge to `out_valid` high:
  - Bypass: 1 edge.
  - Already-normalised: 2 edges.
  - k shifts: k+2 edges.
- No overlap: only one word is in flight. The next accept happens no earlier than the edge after the `out_ready` handshake.
- `in_ready` and `out_valid` are decoded from registered state, with no combinational path from `out_ready`.

## Configuration
- `NORM_RNE_ROUND_EN` defined: round-to-nearest-even. Increment mant when guard & (sticky | mant[0]).
- Undefined: truncate, using mant = product[49:23]. Guard and sticky logic are not built.
- Latency is identical in both builds.

## Structure
- Shared package `hcordic_pkg`:
  - `mode_circular`/`mode_linear`/`mode_hyperbolic`.
  - `no_idle`/`allign_idle`/`put_idle`.
  - `zout` field positions (SIGN=35, EXP 34:27, MANT 26:0).
  - FSM state encoding.
- One sub-module, `round_mant27`: combinational mant/guard/sticky → rounded mant plus carry. It contains the macro-controlled logic.

## Test plan
- Bypass: idle=01, zout=36'h123456789 → zout_Normalise identical, out_valid after 1 edge, tag preserved.
- Normalised: product=50'h2_0000_0000_0000 (bit 49), exp 8'h05 → mantissa 27'h4000000, exp 05, out_valid after 2 edges.
- Shift: product bit 46 only, exp 8'h05 → 3 shifts, exp 8'h02, mantissa 27'h4000000, out_valid after 5 edges.
- Round carry (RNE build): product[49:22] all ones → mantissa 27'h4000000, exp+1. Truncate build: mantissa 27'h7FFFFFF.
- Backpressure + reset: hold out_ready=0 for 10 cycles; outputs stable, in_ready=0. Assert reset_n=0 mid-SHIFT → immediately out_valid=0, in_ready=1, outputs 0.
- Zero product, exp 8'h10, sign 1 → zout_Normalise = 36'h800000000.
